// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: widths, FSM state encodings
// and handshake constants used by div_seq and its EX-side partner.
package div_seq_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider handshake bundle. EX drives the request side (master),
// the divider returns result/ready/busy (slave).
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);

    logic                  start_i;
    logic                  annul_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration. Kept combinational and standalone so
// it can be replicated for a higher-radix variant.
module div_seq_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W:0]   work_next
);

    logic [DATA_W:0] diff;

    // The partial remainder sits just above the quotient/dividend field; a set
    // borrow bit means the divisor did not fit this round.
    assign diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

    always_comb begin
        if (diff[DATA_W]) begin
            work_next = {work, 1'b0};
        end else begin
            work_next = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU controller: 32 shift-subtract iterations on operand
// magnitudes, then a sign fix-up, presenting {remainder, quotient} to EX.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    div_state_e          state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [2*DATA_W:0]   work, work_d, step_out;
    logic [DATA_W-1:0]   divisor_abs, divisor_abs_d;
    logic                is_signed, is_signed_d;
    logic                dividend_neg, dividend_neg_d;
    logic                divisor_neg, divisor_neg_d;
    logic [2*DATA_W-1:0] result, result_d;
    logic                ready, ready_d;
    logic [DATA_W-1:0]   op1_abs, op2_abs, quot, rem;

    assign op1_abs = (bus.signed_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = (bus.signed_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // The remainder takes the dividend's sign; the quotient is negative when signs differ.
    assign quot = (is_signed && (dividend_neg ^ divisor_neg)) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
    assign rem  = (is_signed && dividend_neg) ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .work      (work[2*DATA_W-1:0]),
        .divisor   (divisor_abs),
        .work_next (step_out)
    );

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        work_d         = work;
        divisor_abs_d  = divisor_abs;
        is_signed_d    = is_signed;
        dividend_neg_d = dividend_neg;
        divisor_neg_d  = divisor_neg;
        result_d       = result;
        ready_d        = ready;
        case (state)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next     = DivOn;
                        cnt_next       = '0;
                        is_signed_d    = bus.signed_i;
                        dividend_neg_d = bus.signed_i & bus.opdata1_i[DATA_W-1];
                        divisor_neg_d  = bus.signed_i & bus.opdata2_i[DATA_W-1];
                        divisor_abs_d  = op2_abs;
                        work_d         = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                    end
                end
            end
            DivByZero: begin
                result_d = '0;
                if (bus.annul_i) begin
                    state_next = DivFree;
                    ready_d    = DivResultNotReady;
                end else begin
                    state_next = DivEnd;
                    ready_d    = DivResultReady;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_next = DivFree;
                    result_d   = '0;
                    ready_d    = DivResultNotReady;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    work_d   = step_out;
                    cnt_next = cnt + CNT_W'(1);
                end else begin
                    state_next = DivEnd;
                    result_d   = {rem, quot};
                    ready_d    = DivResultReady;
                end
            end
            DivEnd: begin
                if (bus.annul_i || bus.start_i == DivStop) begin
                    state_next = DivFree;
                    result_d   = '0;
                    ready_d    = DivResultNotReady;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DivFree;
            cnt          <= '0;
            work         <= '0;
            divisor_abs  <= '0;
            is_signed    <= 1'b0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            result       <= '0;
            ready        <= DivResultNotReady;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            work         <= work_d;
            divisor_abs  <= divisor_abs_d;
            is_signed    <= is_signed_d;
            dividend_neg <= dividend_neg_d;
            divisor_neg  <= divisor_neg_d;
            result       <= result_d;
            ready        <= ready_d;
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign bus.busy_o   = (state != DivFree);

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: hand-computed quotients/remainders,
// latency, divide-by-zero, annul, async reset and the signed overflow case.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    div_seq_if bus();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic annul, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.start_i   = start;
        bus.annul_i   = annul;
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
    endtask

    // Counts edges from the start-sampling edge to the first ready observation.
    task automatic waitReady(input string tag, input int exp_latency);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready_o && n < 60);
        checkOutput({tag, "_latency"}, 64'(n - 1), 64'(exp_latency));
    endtask

    task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] expected);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, sgn, a, b);
        waitReady(tag, 33);
        checkOutput({tag, "_result"}, bus.result_o, expected);
        checkOutput({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
        // Operand changes while held must not disturb the presented result.
        applyStimulus(1'b1, 1'b0, ~sgn, 32'h1234_5678, 32'h0000_0000);
        repeat (2) @(negedge clk);
        checkOutput({tag, "_held"}, {bus.result_o[62:0], bus.ready_o}, {expected[62:0], 1'b1});
        applyStimulus(1'b0, 1'b0, sgn, a, b);
        @(negedge clk);
        checkOutput({tag, "_drop"}, {bus.result_o[61:0], bus.ready_o, bus.busy_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saw_ready;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        checkOutput("reset_result", bus.result_o, 64'd0);
        checkOutput("reset_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        runDivide("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        runDivide("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runDivide("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        runDivide("udiv_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
        runDivide("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        runDivide("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});

        // Divide by zero walks BYZERO then END.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        @(negedge clk);
        checkOutput("byzero_state", {62'd0, bus.ready_o, bus.busy_o}, 64'b01);
        @(negedge clk);
        checkOutput("byzero_end", {62'd0, bus.ready_o, bus.busy_o}, 64'b11);
        checkOutput("byzero_result", bus.result_o, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
        @(negedge clk);
        checkOutput("byzero_drop", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);

        // Annul part-way through a divide.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(negedge clk);
        checkOutput("annul_busy_before", 64'(bus.busy_o), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3);
        @(negedge clk);
        checkOutput("annul_free", {bus.result_o[61:0], bus.ready_o, bus.busy_o}, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3);
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_ready = 1'b1;
        end
        checkOutput("annul_no_ready", 64'(saw_ready), 64'd0);
        runDivide("udiv_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // Start with annul in FREE must not begin a divide.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd9, 32'd3);
        repeat (3) @(negedge clk);
        checkOutput("annul_beats_start", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
        @(negedge clk);

        // Async reset off-edge in the middle of ON.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_on", {bus.result_o[61:0], bus.ready_o, bus.busy_o}, 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_release_idle", {bus.result_o[61:0], bus.ready_o, bus.busy_o}, 64'd0);

        // Async reset while a result is being presented clears it at once.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        waitReady("rst_end", 33);
        checkOutput("rst_end_result", bus.result_o, {32'd2, 32'd14});
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_end", bus.result_o, 64'd0);
        checkOutput("rst_mid_end_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
